// File: rtl/pipe_pkg.sv
// Shared pipeline types for the decode/execute boundary: control bundle,
// bubble constant and default datapath widths.
package pipe_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [2:0] alu_ctrl;
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic       mem_read;
    logic [1:0] result_src;
    logic       jump;
    logic       branch;
    logic       branch_neg;
    logic       pc_op;
    logic [2:0] funct3;
  } id_ex_ctrl_t;

  localparam id_ex_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector: flags a decode instruction that reads the
// destination of a load sitting in execute, and derives the fetch/decode stall.
module hazard_detect
  import pipe_pkg::*;
#(
  parameter int REG_AW_P = REG_AW
) (
  input  logic              e_valid,
  input  logic              e_mem_read,
  input  logic [REG_AW_P-1:0] e_rd,
  input  logic              d_valid,
  input  logic [REG_AW_P-1:0] d_rs1,
  input  logic [REG_AW_P-1:0] d_rs2,
  input  logic              flush_e,
  input  logic              hold,
  output logic              lu,
  output logic              stall_fd
);

  // rs2 is compared even when the instruction does not read it.
  assign lu = e_valid & e_mem_read & (e_rd != '0) & d_valid &
              ((e_rd == d_rs1) | (e_rd == d_rs2));

  assign stall_fd = lu & ~flush_e & ~hold;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and execute-side squash.
// Optional performance counters are built when ID_EX_PERF_EN is defined.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int XLEN   = pipe_pkg::XLEN,
  parameter int REG_AW = pipe_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              d_valid,
  input  logic [2:0]        d_alu_ctrl,
  input  logic              d_reg_write,
  input  logic              d_alu_src,
  input  logic              d_mem_write,
  input  logic              d_mem_read,
  input  logic [1:0]        d_result_src,
  input  logic              d_jump,
  input  logic              d_branch,
  input  logic              d_branch_neg,
  input  logic              d_pc_op,
  input  logic [2:0]        d_funct3,
  input  logic [XLEN-1:0]   d_rd1,
  input  logic [XLEN-1:0]   d_rd2,
  input  logic [XLEN-1:0]   d_imm,
  input  logic [XLEN-1:0]   d_pc,
  input  logic [XLEN-1:0]   d_pc_plus4,
  input  logic [REG_AW-1:0] d_rs1,
  input  logic [REG_AW-1:0] d_rs2,
  input  logic [REG_AW-1:0] d_rd,
  input  logic              flush_e,
  input  logic              hold,
  output logic              e_valid,
  output logic [2:0]        e_alu_ctrl,
  output logic              e_reg_write,
  output logic              e_alu_src,
  output logic              e_mem_write,
  output logic              e_mem_read,
  output logic [1:0]        e_result_src,
  output logic              e_jump,
  output logic              e_branch,
  output logic              e_branch_neg,
  output logic              e_pc_op,
  output logic [2:0]        e_funct3,
  output logic [XLEN-1:0]   e_rd1,
  output logic [XLEN-1:0]   e_rd2,
  output logic [XLEN-1:0]   e_imm,
  output logic [XLEN-1:0]   e_pc,
  output logic [XLEN-1:0]   e_pc_plus4,
  output logic [REG_AW-1:0] e_rs1,
  output logic [REG_AW-1:0] e_rs2,
  output logic [REG_AW-1:0] e_rd,
  output logic              stall_fd
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]       perf_stalls,
  output logic [31:0]       perf_flushes
`endif
);

  id_ex_ctrl_t d_ctrl;
  id_ex_ctrl_t e_ctrl;
  logic        lu;

  assign d_ctrl = '{
    alu_ctrl:   d_alu_ctrl,
    reg_write:  d_reg_write,
    alu_src:    d_alu_src,
    mem_write:  d_mem_write,
    mem_read:   d_mem_read,
    result_src: d_result_src,
    jump:       d_jump,
    branch:     d_branch,
    branch_neg: d_branch_neg,
    pc_op:      d_pc_op,
    funct3:     d_funct3
  };

  hazard_detect #(
    .REG_AW_P (REG_AW)
  ) u_hazard (
    .e_valid    (e_valid),
    .e_mem_read (e_ctrl.mem_read),
    .e_rd       (e_rd),
    .d_valid    (d_valid),
    .d_rs1      (d_rs1),
    .d_rs2      (d_rs2),
    .flush_e    (flush_e),
    .hold       (hold),
    .lu         (lu),
    .stall_fd   (stall_fd)
  );

  // hold outranks flush so a squash requested during a freeze lands afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_valid    <= 1'b0;
      e_ctrl     <= CTRL_BUBBLE;
      e_rd1      <= '0;
      e_rd2      <= '0;
      e_imm      <= '0;
      e_pc       <= '0;
      e_pc_plus4 <= '0;
      e_rs1      <= '0;
      e_rs2      <= '0;
      e_rd       <= '0;
    end else if (hold) begin
      e_valid <= e_valid;
    end else if (flush_e || lu) begin
      e_valid    <= 1'b0;
      e_ctrl     <= CTRL_BUBBLE;
      e_rd1      <= '0;
      e_rd2      <= '0;
      e_imm      <= '0;
      e_pc       <= '0;
      e_pc_plus4 <= '0;
      e_rs1      <= '0;
      e_rs2      <= '0;
      e_rd       <= '0;
    end else begin
      e_valid    <= d_valid;
      e_ctrl     <= d_ctrl;
      e_rd1      <= d_rd1;
      e_rd2      <= d_rd2;
      e_imm      <= d_imm;
      e_pc       <= d_pc;
      e_pc_plus4 <= d_pc_plus4;
      e_rs1      <= d_rs1;
      e_rs2      <= d_rs2;
      e_rd       <= d_rd;
    end
  end

  assign e_alu_ctrl   = e_ctrl.alu_ctrl;
  assign e_reg_write  = e_ctrl.reg_write;
  assign e_alu_src    = e_ctrl.alu_src;
  assign e_mem_write  = e_ctrl.mem_write;
  assign e_mem_read   = e_ctrl.mem_read;
  assign e_result_src = e_ctrl.result_src;
  assign e_jump       = e_ctrl.jump;
  assign e_branch     = e_ctrl.branch;
  assign e_branch_neg = e_ctrl.branch_neg;
  assign e_pc_op      = e_ctrl.pc_op;
  assign e_funct3     = e_ctrl.funct3;

`ifdef ID_EX_PERF_EN
  // Counters wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stalls  <= '0;
      perf_flushes <= '0;
    end else begin
      if (stall_fd)
        perf_stalls <= perf_stalls + 32'd1;
      if (flush_e && !hold)
        perf_flushes <= perf_flushes + 32'd1;
    end
  end
`endif

endmodule
